// File: rtl/gpif_rx_pattern_checker.sv
// Checks the host->FPGA incrementing-word packet pattern on the GPIF clock domain.
// Exposes good-packet and error statistics, first-error capture and a per-packet LED toggle.
`timescale 1ns/1ps
module gpif_rx_pattern_checker #(
  parameter int DATA_W    = 32,
  parameter int PKT_WORDS = 4096,
  parameter int CNT_W     = 32
) (
  input  logic              gpif_clk,
  input  logic              gpif_rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              enb,
  input  logic              clr,
  output logic              locked,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  data_err_cnt,
  output logic [CNT_W-1:0]  len_err_cnt,
  output logic              err_sticky,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic              led
);
  localparam int IDX_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

  typedef enum logic {HUNT, CHECK} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pkt_bad_q, pkt_bad_d;
  logic [CNT_W-1:0]  pkt_cnt_q, data_err_cnt_q, len_err_cnt_q;
  logic              err_sticky_q, have_first_q, led_q;
  logic [DATA_W-1:0] first_exp_q, first_act_q;

  logic              beat, mismatch, ev_data_err, ev_len_err, ev_pkt_good;
  logic [DATA_W-1:0] expected;

  assign s_tready = enb & ~gpif_rst;
  assign beat     = s_tvalid & s_tready;
  assign expected = DATA_W'(idx_q);
  assign mismatch = (s_tdata != expected);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge gpif_clk) begin
    if (gpif_rst) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      pkt_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pkt_bad_q <= pkt_bad_d;
    end
  end

  // pkt_bad tracks data errors inside the current packet so a corrupted
  // packet is never counted as good, even if clr discarded its error event.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pkt_bad_d   = pkt_bad_q;
    ev_data_err = 1'b0;
    ev_len_err  = 1'b0;
    ev_pkt_good = 1'b0;
    if (beat) begin
      case (state_q)
        HUNT: begin
          if (s_tlast) begin
            state_d   = CHECK;
            idx_d     = '0;
            pkt_bad_d = 1'b0;
          end
        end
        CHECK: begin
          ev_data_err = mismatch;
          if (s_tlast && idx_q == LAST_IDX) begin
            ev_pkt_good = ~pkt_bad_q & ~mismatch;
            idx_d       = '0;
            pkt_bad_d   = 1'b0;
          end else if (s_tlast) begin
            ev_len_err = 1'b1;
            idx_d      = '0;
            pkt_bad_d  = 1'b0;
          end else if (idx_q == LAST_IDX) begin
            ev_len_err = 1'b1;
            state_d    = HUNT;
            idx_d      = '0;
            pkt_bad_d  = 1'b0;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            pkt_bad_d = pkt_bad_q | mismatch;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // clr discards this cycle's events for statistics; led keeps toggling.
  always_ff @(posedge gpif_clk) begin
    if (gpif_rst) begin
      pkt_cnt_q      <= '0;
      data_err_cnt_q <= '0;
      len_err_cnt_q  <= '0;
      err_sticky_q   <= 1'b0;
      have_first_q   <= 1'b0;
      first_exp_q    <= '0;
      first_act_q    <= '0;
      led_q          <= 1'b0;
    end else begin
      if (ev_pkt_good) led_q <= ~led_q;
      if (clr) begin
        pkt_cnt_q      <= '0;
        data_err_cnt_q <= '0;
        len_err_cnt_q  <= '0;
        err_sticky_q   <= 1'b0;
        have_first_q   <= 1'b0;
        first_exp_q    <= '0;
        first_act_q    <= '0;
      end else begin
        if (ev_pkt_good) pkt_cnt_q <= sat_inc(pkt_cnt_q);
        if (ev_len_err)  len_err_cnt_q <= sat_inc(len_err_cnt_q);
        if (ev_data_err) data_err_cnt_q <= sat_inc(data_err_cnt_q);
        if (ev_data_err || ev_len_err) err_sticky_q <= 1'b1;
        if (ev_data_err && !have_first_q) begin
          have_first_q <= 1'b1;
          first_exp_q  <= expected;
          first_act_q  <= s_tdata;
        end
      end
    end
  end

  assign locked        = (state_q == CHECK);
  assign pkt_cnt       = pkt_cnt_q;
  assign data_err_cnt  = data_err_cnt_q;
  assign len_err_cnt   = len_err_cnt_q;
  assign err_sticky    = err_sticky_q;
  assign first_err_exp = first_exp_q;
  assign first_err_act = first_act_q;
  assign led           = led_q;
endmodule

// File: tb/tb_gpif_rx_pattern_checker.sv
// Directed scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_gpif_rx_pattern_checker;
  localparam int DW = 32;
  localparam int PW = 4096;
  localparam int CW = 32;

  logic          gpif_clk = 1'b0;
  logic          gpif_rst = 1'b1;
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tlast  = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          enb = 1'b1;
  logic          clr = 1'b0;
  logic          locked, err_sticky, led;
  logic [CW-1:0] pkt_cnt, data_err_cnt, len_err_cnt;
  logic [DW-1:0] first_err_exp, first_err_act;

  gpif_rx_pattern_checker #(.DATA_W(DW), .PKT_WORDS(PW), .CNT_W(CW)) dut (
    .gpif_clk(gpif_clk), .gpif_rst(gpif_rst), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .enb(enb), .clr(clr), .locked(locked),
    .pkt_cnt(pkt_cnt), .data_err_cnt(data_err_cnt), .len_err_cnt(len_err_cnt),
    .err_sticky(err_sticky), .first_err_exp(first_err_exp), .first_err_act(first_err_act),
    .led(led)
  );

  always #5 gpif_clk = ~gpif_clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] act_of(input int sel);
    case (sel)
      0: return {31'b0, locked};
      1: return pkt_cnt;
      2: return data_err_cnt;
      3: return len_err_cnt;
      4: return {31'b0, err_sticky};
      5: return first_err_exp;
      6: return first_err_act;
      7: return {31'b0, led};
      8: return {31'b0, s_tready};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: drains everything queued for this cycle at the falling edge.
  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge gpif_clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = act_of(e.sel);
        total++;
        if (a !== e.val) begin
          bad++;
          $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
        end
      end
    end
  end

  task automatic push(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.val = v;
    q.push_back(e);
  endtask

  task automatic expect_all(input string t, input logic lk, input logic [31:0] pk,
                            input logic [31:0] de, input logic [31:0] le, input logic st,
                            input logic ld, input logic [31:0] fe, input logic [31:0] fa);
    push({t, ".locked"}, 0, {31'b0, lk});
    push({t, ".pkt_cnt"}, 1, pk);
    push({t, ".data_err_cnt"}, 2, de);
    push({t, ".len_err_cnt"}, 3, le);
    push({t, ".err_sticky"}, 4, {31'b0, st});
    push({t, ".led"}, 7, {31'b0, ld});
    push({t, ".first_err_exp"}, 5, fe);
    push({t, ".first_err_act"}, 6, fa);
  endtask

  task automatic drain(input string t);
    @(posedge gpif_clk); #1;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s.drain: got %0d pending expected 0", t, q.size());
      q.delete();
    end
  endtask

  task automatic do_reset(input string t);
    s_tvalid = 1'b0; clr = 1'b0; enb = 1'b1; gpif_rst = 1'b1;
    @(posedge gpif_clk); #1;
    push({t, ".tready_in_rst"}, 8, 32'd0);
    expect_all(t, 0, 0, 0, 0, 0, 0, 0, 0);
    drain(t);
    gpif_rst = 1'b0;
  endtask

  // One beat; with rnd set, enb is randomised each cycle until the word is taken.
  task automatic send_word(input logic [31:0] d, input logic l, input bit rnd);
    bit acc = 1'b0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    for (int tries = 0; tries < 64 && !acc; tries++) begin
      if (rnd) begin
        enb = 1'($urandom_range(0, 1));
        push("tready_tracks_enb", 8, {31'b0, enb});
      end
      acc = enb;
      @(posedge gpif_clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; enb = 1'b1;
    if (!acc) begin
      total++; bad++;
      $display("FAIL beat_timeout: got no accept expected accept within 64 cycles");
    end
  endtask

  task automatic send_pkt(input int n, input int bad_idx, input logic [31:0] bad_val,
                          input bit last_at_end, input bit rnd);
    for (int i = 0; i < n; i++)
      send_word((i == bad_idx) ? bad_val : 32'(i), last_at_end && (i == n - 1), rnd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge gpif_clk); #1;

    // 1: junk then three good packets
    do_reset("t1_reset");
    send_word(32'hAAAA_0000, 0, 0);
    send_word(32'hAAAA_0001, 0, 0);
    expect_all("t1_hunt", 0, 0, 0, 0, 0, 0, 0, 0); drain("t1");
    send_word(32'hAAAA_0002, 1, 0);
    expect_all("t1_lock", 1, 0, 0, 0, 0, 0, 0, 0); drain("t1");
    for (int p = 0; p < 3; p++) send_pkt(PW, -1, 0, 1, 0);
    expect_all("t1_done", 1, 3, 0, 0, 0, 1, 0, 0); drain("t1");

    // 2: word 100 of packet 2 corrupted
    do_reset("t2_reset");
    send_word(32'h1234_5678, 1, 0);
    send_pkt(PW, -1, 0, 1, 0);
    send_pkt(PW, 100, 32'hDEAD_BEEF, 1, 0);
    send_pkt(PW, -1, 0, 1, 0);
    expect_all("t2_done", 1, 2, 1, 0, 1, 0, 100, 32'hDEAD_BEEF); drain("t2");

    // 3: short packet then a good one
    do_reset("t3_reset");
    send_word(32'h0, 1, 0);
    send_pkt(2048, -1, 0, 1, 0);
    expect_all("t3_short", 1, 0, 0, 1, 1, 0, 0, 0); drain("t3");
    send_pkt(PW, -1, 0, 1, 0);
    expect_all("t3_good", 1, 1, 0, 1, 1, 1, 0, 0); drain("t3");

    // 4: long packet drops lock, re-hunt, then a good one
    do_reset("t4_reset");
    send_word(32'h0, 1, 0);
    send_pkt(PW, -1, 0, 0, 0);
    expect_all("t4_long", 0, 0, 0, 1, 1, 0, 0, 0); drain("t4");
    send_word(32'h55, 1, 0);
    expect_all("t4_relock", 1, 0, 0, 1, 1, 0, 0, 0); drain("t4");
    send_pkt(PW, -1, 0, 1, 0);
    expect_all("t4_good", 1, 1, 0, 1, 1, 1, 0, 0); drain("t4");

    // 5: random enb with tvalid held high
    do_reset("t5_reset");
    send_word(32'h0, 1, 0);
    send_pkt(PW, -1, 0, 1, 1);
    send_pkt(PW, -1, 0, 1, 1);
    expect_all("t5_done", 1, 2, 0, 0, 0, 0, 0, 0); drain("t5");

    // 6: clr on an erroneous beat, then reset mid-packet
    do_reset("t6_reset");
    send_word(32'h0, 1, 0);
    send_pkt(PW, -1, 0, 1, 0);
    send_word(32'd0, 0, 0);
    send_word(32'h11, 0, 0);
    expect_all("t6_err", 1, 1, 1, 0, 1, 1, 1, 32'h11); drain("t6");
    clr = 1'b1;
    send_word(32'h22, 0, 0);
    clr = 1'b0;
    expect_all("t6_clr", 1, 0, 0, 0, 0, 1, 0, 0); drain("t6");
    send_word(32'd3, 0, 0);
    send_word(32'h44, 0, 0);
    expect_all("t6_after", 1, 0, 1, 0, 1, 1, 4, 32'h44); drain("t6");
    do_reset("t6_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpif_rx_pattern_checker.md
Name: gpif_rx_pattern_checker

Overview:
- Downstream-direction counterpart to the upstream counter-pattern generator.
- Sinks the TX data stream from gpif2_to_fifo32 (host -> FPGA) on the 100 MHz GPIF clock domain.
- The host sends the same incrementing-word pattern, with tlast marking each packet; this block checks it and exposes packet/error statistics plus a per-packet LED toggle for bring-up.

Parameters:
- DATA_W, 32, stream data width.
- PKT_WORDS, 4096, words per packet; expected tlast on word index PKT_WORDS-1.
- CNT_W, 32, width of all statistics counters.

Ports:
- gpif_clk  input  1  GPIF domain clock, 100 MHz.
- gpif_rst  input  1  synchronous, active-high reset.
- s_tdata  input  DATA_W  stream data from gpif2_to_fifo32 tx_tdata.
- s_tlast  input  1  end-of-packet marker.
- s_tvalid  input  1  beat valid.
- s_tready  output  1  beat accept.
- enb  input  1  accept enable; when low, s_tready=0.
- clr  input  1  synchronous one-cycle clear of statistics and sticky flags.
- locked  output  1  high while in CHECK state.
- pkt_cnt  output  CNT_W  good packets received.
- data_err_cnt  output  CNT_W  words with data mismatch.
- len_err_cnt  output  CNT_W  packets with wrong length.
- err_sticky  output  1  set on any error; cleared by clr/reset.
- first_err_exp  output  DATA_W  expected value at first data error since clr.
- first_err_act  output  DATA_W  received value at first data error since clr.
- led  output  1  toggles on every good packet.

Behaviour:
- Beat = s_tvalid & s_tready. s_tready = enb & ~gpif_rst (combinational; no backpressure otherwise).
- Reset values: s_tready 0 during reset, locked 0, all counters 0, err_sticky 0, first_err_* 0, led 0, FSM=HUNT, idx=0.
- FSM HUNT: consume beats without checking. On a beat with s_tlast=1 -> CHECK, idx<=0. Data and length errors are not counted in HUNT.
- FSM CHECK: idx = word position in packet, expected = idx zero-extended to DATA_W.
  - Beat with s_tdata != expected -> data_err_cnt++; err_sticky<=1. If first error since clr, capture first_err_exp/act.
  - Beat with s_tlast=1 and idx==PKT_WORDS-1 -> packet complete; idx<=0. If no data error occurred in this packet, pkt_cnt++ and led toggles.
  - Beat with s_tlast=1 and idx<PKT_WORDS-1 (short packet) -> len_err_cnt++; err_sticky<=1; idx<=0; stay in CHECK.
  - Beat with s_tlast=0 and idx==PKT_WORDS-1 (long packet) -> len_err_cnt++; err_sticky<=1; go to HUNT.
  - Any other beat -> idx++.
- A word can be both data error and length error; both counters increment.
- Latency: all statistics outputs and locked update on the clock edge after the accepting beat (1 cycle, registered).
- Counters saturate at all-ones; they do not wrap.
- clr in the same cycle as a beat:
  - clr wins for counters, sticky flag and captures: they go to 0, and that beat's events are discarded.
  - FSM and idx still advance normally.
  - led is not affected by clr.
- enb low mid-packet: no beats are accepted; FSM/idx hold; checking resumes on the same idx.
- gpif_rst mid-packet: immediate return to reset values next edge; partial packet discarded; re-hunt required.

Test Plan:
- 3 packets of words 0..4095, tlast on 4095, first preceded by one junk packet ending in tlast -> locked=1 after junk tlast; pkt_cnt=3, data_err_cnt=0, len_err_cnt=0, led toggled 3 times, err_sticky=0.
- Good stream with word 100 of packet 2 corrupted to 0xDEADBEEF -> data_err_cnt=1, pkt_cnt=2 (of 3), first_err_exp=100, first_err_act=0xDEADBEEF, err_sticky=1.
- tlast on word 2047 (short packet), then a good packet -> len_err_cnt=1, locked stays 1, following packet counted (pkt_cnt +1).
- Word 4095 without tlast -> len_err_cnt=1, locked=0 next cycle; after next tlast and a good packet, locked=1 and pkt_cnt increments.
- enb toggled randomly 50% with s_tvalid held high, 2 good packets -> s_tready tracks enb, pkt_cnt=2, no errors.
- clr asserted coincident with an erroneous beat -> counters read 0 after clr, err_sticky=0; then gpif_rst mid-packet -> all outputs 0, locked=0.
